reorder_ctrl: RTL and testbench

//   Address and bank controller for the two-bank output reorder buffer of the 128-pt SDF FFT.

---
 rtl/reorder_ctrl.sv | 151 +++++++++++++++
 tb/tb_reorder_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reorder_ctrl
// Description : Address/bank controller for the two-bank output reorder buffer
//               of a 128-point SDF FFT. Writes bit-reversed samples at
//               bitrev(index) in the active bank, then sweeps the read select
//               in natural order over each completed bank (ping-pong).
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_ctrl #(
  parameter int LOG_L_FFT = 7,
  parameter int N_REG     = 128,
  parameter int B_RE      = 41
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [2*B_RE-1:0]      in_data,
  output logic [2*B_RE-1:0]      wr_data,
  output logic [2*N_REG-1:0]     en_reg_out_bus,
  output logic [LOG_L_FFT-1:0]   sel_out,
  output logic                   sel_bank_out,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_last
);

  localparam logic [LOG_L_FFT-1:0] c_LAST = {LOG_L_FFT{1'b1}};
  localparam logic [2*N_REG-1:0]   c_ONE  = {{(2*N_REG-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  // Write-side state
  logic [LOG_L_FFT-1:0] wr_cnt_q,  wr_cnt_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [2*B_RE-1:0]    wr_data_q, wr_data_d;
  logic [2*N_REG-1:0]   en_q,      en_d;
  logic [1:0]           full_q,    full_d;

  // Read-side state
  state_t               state_q,   state_d;
  logic [LOG_L_FFT-1:0] rd_cnt_q,  rd_cnt_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sof_q,   out_sof_d;
  logic                 out_last_q,  out_last_d;

  logic [LOG_L_FFT-1:0] w_k;
  logic [LOG_L_FFT-1:0] w_rev;
  logic [LOG_L_FFT:0]   w_en_idx;
  logic                 w_wr_done;
  logic                 w_rd_done;

  // Write address: index within frame, its bit reversal and the one-hot enable.
  // Bank0 occupies the upper half of the enable bus, hence the inverted bank bit as MSB.
  always_comb begin
    w_k = in_sof ? '0 : wr_cnt_q;
    for (int i = 0; i < LOG_L_FFT; i++) begin
      w_rev[i] = w_k[LOG_L_FFT-1-i];
    end
    w_en_idx  = {~wr_bank_q, w_rev};
    w_wr_done = in_valid && (w_k == c_LAST);

    wr_cnt_d  = in_valid ? (w_k + 1'b1) : wr_cnt_q;
    wr_bank_d = wr_bank_q ^ w_wr_done;
    wr_data_d = in_valid ? in_data : wr_data_q;
    en_d      = in_valid ? (c_ONE << w_en_idx) : '0;
  end

  // Read sequencer: pick a full bank, sweep it 0..L-1, chain straight into the other bank if ready.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    w_rd_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|full_q) begin
          state_d   = S_DRAIN;
          rd_cnt_d  = '0;
          rd_bank_d = (full_q[0] && full_q[1]) ? ~rd_bank_q : full_q[1];
        end
      end
      S_DRAIN: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == c_LAST) begin
          w_rd_done = 1'b1;
          if (full_q[~rd_bank_q]) begin
            rd_bank_d = ~rd_bank_q;
          end else begin
            state_d  = S_IDLE;
            rd_cnt_d = rd_cnt_q;   // selects hold while idle
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A bank being drained cannot refill before its drain ends, so set/clear never collide.
    full_d = full_q;
    if (w_rd_done) full_d = full_d & ~(2'b01 << rd_bank_q);
    if (w_wr_done) full_d = full_d |  (2'b01 << wr_bank_q);

    out_valid_d = (state_q == S_DRAIN);
    out_sof_d   = (state_q == S_DRAIN) && (rd_cnt_q == '0);
    out_last_d  = (state_q == S_DRAIN) && (rd_cnt_q == c_LAST);
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      wr_data_q   <= '0;
      en_q        <= '0;
      full_q      <= '0;
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      wr_data_q   <= wr_data_d;
      en_q        <= en_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_last_q  <= out_last_d;
    end
  end

  assign wr_data        = wr_data_q;
  assign en_reg_out_bus = en_q;
  assign sel_out        = rd_cnt_q;
  assign sel_bank_out   = rd_bank_q;
  assign out_valid      = out_valid_q;
  assign out_sof        = out_sof_q;
  assign out_last       = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_ctrl
// Description : Scoreboard bench for reorder_ctrl with a behavioural model of
//               the two-bank reorder buffer and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_ctrl;

  localparam int LOGL = 7;
  localparam int N    = 128;
  localparam int B    = 41;
  localparam int W    = 2*B;
  localparam int L    = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic [W-1:0]    wr_data;
  logic [2*N-1:0]  en_reg_out_bus;
  logic [LOGL-1:0] sel_out;
  logic            sel_bank_out;
  logic            out_valid;
  logic            out_sof;
  logic            out_last;

  reorder_ctrl #(.LOG_L_FFT(LOGL), .N_REG(N), .B_RE(B)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .wr_data(wr_data), .en_reg_out_bus(en_reg_out_bus), .sel_out(sel_out),
    .sel_bank_out(sel_bank_out), .out_valid(out_valid), .out_sof(out_sof),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    bit           sof;
    bit           last;
    bit           bank;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            last_cyc = 0;
  int            exp_sof_cyc = -1;
  int            run = 0;
  int            max_run = 0;

  logic [W-1:0]  fr[L];
  int            m_cnt  = 0;
  bit            m_bank = 1'b0;
  bit            m_rst  = 1'b0;
  bit            m_v    = 1'b0;
  int            m_idx  = 0;
  logic [W-1:0]  m_data = '0;

  logic [W-1:0]  mem[2][N];
  logic [W-1:0]  buf_d;
  bit            buf_bank;

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LOGL; i++) r |= ((k >> i) & 1) << (LOGL-1-i);
    return r;
  endfunction

  // Buffer model and reference model, both sampled on the active edge
  always @(posedge clk) begin
    int k;
    cyc++;
    buf_d    = mem[sel_bank_out][sel_out];
    buf_bank = sel_bank_out;
    for (int i = 0; i < 2*N; i++) begin
      if (en_reg_out_bus[i]) begin
        if (i >= N) mem[0][i-N] = wr_data;
        else        mem[1][i]   = wr_data;
      end
    end
    m_rst = rst;
    m_v   = in_valid && !rst;
    if (rst) begin
      m_cnt  = 0;
      m_bank = 1'b0;
      exp_q.delete();
    end else if (in_valid) begin
      k       = in_sof ? 0 : m_cnt;
      m_idx   = (m_bank ? 0 : N) + brev(k);
      m_data  = in_data;
      fr[k]   = in_data;
      m_cnt   = (k + 1) % L;
      if (k == L-1) begin
        for (int n = 0; n < L; n++)
          exp_q.push_back('{fr[brev(n)], (n == 0), (n == L-1), m_bank});
        m_bank = !m_bank;
      end
    end
  end

  // Monitor: per-cycle write-port checks and scoreboard pops on out_valid
  always @(negedge clk) begin
    logic [2*N-1:0] e_en;
    exp_t e;
    if (m_rst) begin
      total++;
      if (en_reg_out_bus != '0 || wr_data != '0 || sel_out != '0 || sel_bank_out ||
          out_valid || out_sof || out_last) begin
        bad++;
        $display("FAIL reset_outputs got en=%0d wr=%0h sel=%0d bank=%0d v/s/l=%0d%0d%0d want all 0",
                 $countones(en_reg_out_bus), wr_data, sel_out, sel_bank_out, out_valid, out_sof, out_last);
      end
    end else begin
      e_en = '0;
      if (m_v) e_en[m_idx] = 1'b1;
      total++;
      if (en_reg_out_bus !== e_en) begin
        bad++;
        $display("FAIL write_enable cyc=%0d got popcount=%0d want bit %0d (valid=%0d)",
                 cyc, $countones(en_reg_out_bus), m_idx, m_v);
      end
      if (m_v) begin
        total++;
        if (wr_data !== m_data) begin
          bad++;
          $display("FAIL wr_data cyc=%0d got %0h want %0h", cyc, wr_data, m_data);
        end
      end
    end
    if (out_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cyc=%0d got out_valid=1 want 0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (buf_d !== e.d) begin
          bad++;
          $display("FAIL bin_data cyc=%0d got %0h want %0h", cyc, buf_d, e.d);
        end
        total++;
        if (out_sof !== e.sof || out_last !== e.last || buf_bank !== e.bank) begin
          bad++;
          $display("FAIL bin_flags cyc=%0d got sof=%0d last=%0d bank=%0d want sof=%0d last=%0d bank=%0d",
                   cyc, out_sof, out_last, buf_bank, e.sof, e.last, e.bank);
        end
      end
      if (out_sof === 1'b1 && exp_sof_cyc >= 0) begin
        total++;
        if (cyc != exp_sof_cyc) begin
          bad++;
          $display("FAIL latency got bin0 at cycle %0d want %0d", cyc, exp_sof_cyc);
        end
        exp_sof_cyc = -1;
      end
    end else begin
      run = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit sof);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // gap_mode 0: continuous, 1: one idle cycle after every two samples, 2: random idles
  task automatic send_frame(input bit rnd, input int gap_mode);
    logic [W-1:0] d;
    for (int k = 0; k < L; k++) begin
      d = rnd ? W'({$urandom(), $urandom(), $urandom()}) : W'(k);
      send(d, k == 0);
      if (k != L-1) begin
        if (gap_mode == 1 && (k % 2) == 1) idle(1);
        if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle(1);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      idle(1);
      t++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_%s got %0d bins pending want 0", name, exp_q.size());
    end
    idle(3);
  endtask

  task automatic check_latency_seen(input string name);
    total++;
    if (exp_sof_cyc != -1) begin
      bad++;
      $display("FAIL latency_%s got no bin0 want bin0 at cycle %0d", name, exp_sof_cyc);
      exp_sof_cyc = -1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    idle(2);

    // 1: single frame, in_data = k
    send_frame(1'b0, 0);
    exp_sof_cyc = last_cyc + 3;
    wait_drain("t1");
    check_latency_seen("t1");

    // 2: two back-to-back frames -> 256 contiguous output bins
    do_reset();
    max_run = 0;
    send_frame(1'b1, 0);
    exp_sof_cyc = last_cyc + 3;
    send_frame(1'b1, 0);
    wait_drain("t2");
    check_latency_seen("t2");
    total++;
    if (max_run != 2*L) begin
      bad++;
      $display("FAIL contiguous got run=%0d want %0d", max_run, 2*L);
    end

    // 3: frame with one idle cycle in every three
    send_frame(1'b1, 1);
    exp_sof_cyc = last_cyc + 3;
    wait_drain("t3");
    check_latency_seen("t3");

    // 4: aborted partial frame followed by a full frame
    do_reset();
    for (int k = 0; k < 50; k++) send(W'({$urandom(), $urandom(), $urandom()}), k == 0);
    idle(2);
    send_frame(1'b1, 0);
    exp_sof_cyc = last_cyc + 3;
    wait_drain("t4");
    check_latency_seen("t4");

    // 5: reset in the middle of a drain
    do_reset();
    send_frame(1'b1, 0);
    idle(61);
    total++;
    if (sel_out !== 7'd60 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_drain_pos got sel_out=%0d out_valid=%0d want 60 1", sel_out, out_valid);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(300);
    send_frame(1'b1, 0);
    wait_drain("t5");

    // 7: several frames with random gaps
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(1'b1, 2);
    wait_drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
